frv_mem_port_arbiter: RTL and testbench
=======================================

# frv_mem_port_arbiter

Shares one memory bus between the fetch stage's instruction port and the memory stage's data port. Both ports use the core's req/gnt protocol, in which a response arrives exactly one cycle after grant. The block selects one requester per cycle and locks that selection until the bus grants it. It routes each response's error flag back to the port that owns it, and a streak counter guarantees that fetch cannot be starved by back-to-back data accesses.

## Interface
- `FRV_ARB_MAX_DSTREAK`, default 4: maximum consecutive data grants while fetch is waiting. Legal range is 1..15.
- `g_clk` in 1: global clock.
- `g_resetn` in 1: reset, synchronous, active-low; clock `g_clk`.
- `imem_req`, `imem_wen` in 1: fetch port request and write enable.
- `imem_strb` in 4: fetch port write strobe.
- `imem_addr`, `imem_wdata` in XL+1: fetch port address and write data.
- `imem_gnt`, `imem_error` out 1: fetch port grant and response error.
- `imem_rdata` out XL+1: fetch port read data.
- `dmem_*` (all eight signals above): same set for the data port.
- `mem_req`, `mem_wen` out 1: shared bus request and write enable.
- `mem_strb` out 4: shared bus write strobe.
- `mem_addr`, `mem_wdata` out XL+1: shared bus address and write data.
- `mem_gnt`, `mem_error` in 1: shared bus grant and response error.
- `mem_rdata` in XL+1: shared bus read data.

## Operation
- **State:** `state` ∈ {IDLE, LOCK_I, LOCK_D}, `streak` (4 bits), `rsp_pending`, `rsp_owner` (I/D).
- **Selection in IDLE:**
  - Only one port requesting: select that port.
  - Both requesting: select D, unless `streak == FRV_ARB_MAX_DSTREAK`, in which case select I.
  - Neither requesting: no selection, and `mem_req = 0`.
- **Selection in LOCK_x:** the selection is x, regardless of the other port.
- **Bus outputs:**
  - `mem_req` equals the selected port's req.
  - `mem_addr`, `mem_wen`, `mem_strb` and `mem_wdata` are muxed from the selected port.
  - With no selection, the mux defaults to the I fields.
- **Grants:** `imem_gnt = mem_gnt && mem_req && sel==I`; `dmem_gnt` is the same with `sel==D`. At most one grant per cycle.
- **State transitions:**
  - IDLE → LOCK_x when `mem_req && !mem_gnt` with x selected.
  - LOCK_x → IDLE on `mem_gnt`.
  - An ungranted IDLE selection always locks. Requesters must hold req and payload until grant; withdrawing is a protocol violation and its behaviour is undefined.
- **Response tracking:**
  - On any grant, `rsp_pending <= 1` and `rsp_owner <= sel`; otherwise `rsp_pending <= 0`.
  - `imem_error = mem_error && rsp_pending && rsp_owner==I`; D is analogous.
  - `imem_rdata = dmem_rdata = mem_rdata`, unqualified. Consumers time their use from their own grant.
- **Streak counter:**
  - On a D grant with `imem_req` high: increment, saturating at MAX.
  - On an I grant, or whenever `imem_req` is low: clear.
  - Otherwise: hold.
- **Reset:** while `g_resetn` is low, `mem_req`, `imem_gnt`, `dmem_gnt`, `imem_error` and `dmem_error` are forced to 0. On the next edge `state` becomes IDLE, `streak` 0 and `rsp_pending` 0. Reset mid-lock abandons the lock and produces no spurious error routing.

## Timing
- Request path is combinational, zero cycles from port req to `mem_req`.
- Grant path is combinational from `mem_gnt`.
- Error routing is registered: the owner is captured at the grant edge and applied in the following cycle, which matches the one-cycle bus response latency.
- Back-to-back grants to alternating ports in consecutive cycles are supported, and each response is routed to its own owner.
- Fetch worst-case wait with continuous `mem_gnt`: MAX data grants, then the fetch grant.
- Selection changes only in IDLE; the lock prevents `mem_addr` from changing under an ungranted request.

## Structure
- State encoding (IDLE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2) and owner encoding (I = 0, D = 1) go in `frv_common.svh` alongside XL.
- No sub-module. Single flat module of roughly 150–200 lines.

## Test plan
- **Fetch alone:** `imem_req = 1`, addr 0x8000_0000, `mem_gnt = 1`. Expect `mem_addr = 0x8000_0000` and `imem_gnt = 1` that cycle. Next cycle, `mem_error = 1` gives `imem_error = 1` and `dmem_error = 0`.
- **Starvation bound:** both ports request continuously, MAX = 4, `mem_gnt = 1`. Expect D granted in cycles 0–3, I granted in cycle 4, `streak` returning to 0, then D granted again in cycle 5.
- **Lock:** I selected, `mem_gnt = 0` in cycles 0–2, `dmem_req` rises in cycle 1, `mem_gnt = 1` in cycle 3. Expect `mem_addr` held at the I address throughout, I granted in cycle 3, D granted in cycle 4, and `dmem_gnt = 0` before that.
- **Alternating routing:** D granted in cycle N, I granted in cycle N+1, `mem_error = 1` in both N+1 and N+2. Expect `dmem_error` high only in N+1 and `imem_error` high only in N+2.
- **Reset mid-lock:** in LOCK_D, drive `g_resetn = 0` for 1 cycle. Expect `mem_req = 0` and all grants and errors 0 during reset. After release, `state` is IDLE, `streak` is 0 and `rsp_pending` is 0, and a held `imem_req` is granted immediately.

Source files
------------

// File: rtl/frv_mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
//   XL          : data/address MSB index (buses are XL+1 bits wide)
//   arb_state_e : arbiter lock state
//   arb_owner_e : which port owns a selection or an outstanding response
package frv_mem_port_arbiter_pkg;

  localparam int unsigned XL = 31;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLockI = 2'd1,
    StLockD = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/frv_mem_port_arbiter.sv
// Shares one req/gnt memory bus between the fetch (imem) and data (dmem) ports.
// One requester is selected per cycle; an ungranted selection is locked until
// the bus grants it, so the bus payload never changes under a pending request.
// Responses arrive one cycle after grant and their error flag is routed to the
// port that owned the grant. A streak counter bounds how many data grants can
// be issued back-to-back while fetch is waiting.
//
// Ports:
//   g_clk, g_resetn                 : clock, synchronous active-low reset
//   imem_* / dmem_*                 : requester ports (req, wen, strb, addr,
//                                     wdata in; gnt, error, rdata out)
//   mem_req/wen/strb/addr/wdata     : shared bus request payload (out)
//   mem_gnt, mem_error, mem_rdata   : shared bus grant and response (in)
module frv_mem_port_arbiter
  import frv_mem_port_arbiter_pkg::*;
#(
  parameter int unsigned FRV_ARB_MAX_DSTREAK = 4
) (
  input  logic          g_clk,
  input  logic          g_resetn,

  input  logic          imem_req,
  input  logic          imem_wen,
  input  logic [3:0]    imem_strb,
  input  logic [XL:0]   imem_addr,
  input  logic [XL:0]   imem_wdata,
  output logic          imem_gnt,
  output logic          imem_error,
  output logic [XL:0]   imem_rdata,

  input  logic          dmem_req,
  input  logic          dmem_wen,
  input  logic [3:0]    dmem_strb,
  input  logic [XL:0]   dmem_addr,
  input  logic [XL:0]   dmem_wdata,
  output logic          dmem_gnt,
  output logic          dmem_error,
  output logic [XL:0]   dmem_rdata,

  output logic          mem_req,
  output logic          mem_wen,
  output logic [3:0]    mem_strb,
  output logic [XL:0]   mem_addr,
  output logic [XL:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_error,
  input  logic [XL:0]   mem_rdata
);

  localparam logic [3:0] MaxStreak = 4'(FRV_ARB_MAX_DSTREAK);

  arb_state_e state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       rsp_pending_q, rsp_pending_d;
  arb_owner_e rsp_owner_q, rsp_owner_d;

  logic       sel_valid;
  arb_owner_e sel_owner;
  logic       bus_req;
  logic       bus_gnt;

  // Selection: free choice only in IDLE, otherwise pinned by the lock.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OwnerI;
    unique case (state_q)
      StIdle: begin
        // Data wins a tie unless fetch has already waited out its budget.
        if (dmem_req && (!imem_req || (streak_q != MaxStreak))) begin
          sel_valid = 1'b1;
          sel_owner = OwnerD;
        end else if (imem_req) begin
          sel_valid = 1'b1;
          sel_owner = OwnerI;
        end
      end
      StLockI: begin
        sel_valid = 1'b1;
        sel_owner = OwnerI;
      end
      StLockD: begin
        sel_valid = 1'b1;
        sel_owner = OwnerD;
      end
      default: begin
        sel_valid = 1'b0;
        sel_owner = OwnerI;
      end
    endcase
  end

  // Payload mux falls back to the fetch fields when nothing is selected.
  always_comb begin
    if (sel_owner == OwnerD) begin
      bus_req   = sel_valid && dmem_req;
      mem_wen   = dmem_wen;
      mem_strb  = dmem_strb;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end else begin
      bus_req   = sel_valid && imem_req;
      mem_wen   = imem_wen;
      mem_strb  = imem_strb;
      mem_addr  = imem_addr;
      mem_wdata = imem_wdata;
    end
  end

  // Handshake outputs are held low for the whole reset cycle, not just after it.
  assign mem_req  = g_resetn && bus_req;
  assign bus_gnt  = mem_gnt && mem_req;
  assign imem_gnt = bus_gnt && (sel_owner == OwnerI);
  assign dmem_gnt = bus_gnt && (sel_owner == OwnerD);

  assign imem_error = g_resetn && mem_error && rsp_pending_q && (rsp_owner_q == OwnerI);
  assign dmem_error = g_resetn && mem_error && rsp_pending_q && (rsp_owner_q == OwnerD);

  // Read data is broadcast; each port knows from its own grant when it is valid.
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  // Next-state: lock, response tracking, streak counter.
  always_comb begin
    state_d       = state_q;
    rsp_pending_d = bus_gnt;
    rsp_owner_d   = rsp_owner_q;
    streak_d      = streak_q;

    unique case (state_q)
      StIdle: begin
        if (mem_req && !mem_gnt) begin
          state_d = (sel_owner == OwnerD) ? StLockD : StLockI;
        end
      end
      StLockI, StLockD: begin
        if (mem_gnt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus_gnt) begin
      rsp_owner_d = sel_owner;
    end

    if (dmem_gnt && imem_req) begin
      if (streak_q != MaxStreak) begin
        streak_d = streak_q + 4'd1;
      end
    end else if (imem_gnt || !imem_req) begin
      streak_d = 4'd0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q       <= StIdle;
      streak_q      <= 4'd0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OwnerI;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

endmodule

// File: tb/tb_frv_mem_port_arbiter.sv
// Directed bench for frv_mem_port_arbiter with hand-computed expectations.
module tb_frv_mem_port_arbiter;

  localparam logic [31:0] IAddr  = 32'h8000_0000;
  localparam logic [31:0] DAddr  = 32'h0000_1000;
  localparam logic [31:0] DWdata = 32'hDEAD_BEEF;

  logic        g_clk;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_gnt, imem_error;
  logic [3:0]  imem_strb;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_error;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  frv_mem_port_arbiter #(
    .FRV_ARB_MAX_DSTREAK(4)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .imem_req   (imem_req),
    .imem_wen   (imem_wen),
    .imem_strb  (imem_strb),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_gnt   (imem_gnt),
    .imem_error (imem_error),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_error (dmem_error),
    .dmem_rdata (dmem_rdata),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_error  (mem_error),
    .mem_rdata  (mem_rdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_resetn   = 1'b0;
    imem_req   = 1'b1;
    imem_wen   = 1'b0;
    imem_strb  = 4'b0000;
    imem_addr  = IAddr;
    imem_wdata = 32'h0;
    dmem_req   = 1'b0;
    dmem_wen   = 1'b1;
    dmem_strb  = 4'b0011;
    dmem_addr  = DAddr;
    dmem_wdata = DWdata;
    mem_gnt    = 1'b1;
    mem_error  = 1'b0;
    mem_rdata  = 32'h1234_5678;

    // Reset: handshake outputs forced low even with a request and a grant.
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_imem_gnt", 32'(imem_gnt), 32'd0);
    tick();
    tick();
    g_resetn = 1'b1;
    imem_req = 1'b0;
    mem_gnt  = 1'b0;

    // Idle: no request, payload defaults to fetch fields.
    #2;
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_mem_addr", mem_addr, IAddr);
    check("rdata_bcast", imem_rdata, 32'h1234_5678);
    tick();

    // Fetch alone.
    imem_req = 1'b1;
    mem_gnt  = 1'b1;
    #2;
    check("fetch_addr", mem_addr, IAddr);
    check("fetch_ignt", 32'(imem_gnt), 32'd1);
    check("fetch_dgnt", 32'(dmem_gnt), 32'd0);
    tick();
    imem_req  = 1'b0;
    mem_error = 1'b1;
    #2;
    check("fetch_ierr", 32'(imem_error), 32'd1);
    check("fetch_derr", 32'(dmem_error), 32'd0);
    tick();
    mem_error = 1'b0;

    // Starvation bound: D x4, I, D x4, I.
    imem_req = 1'b1;
    dmem_req = 1'b1;
    mem_gnt  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      automatic logic exp_i = (c == 4) || (c == 9);
      #2;
      check($sformatf("starve_dgnt_c%0d", c), 32'(dmem_gnt), 32'(!exp_i));
      check($sformatf("starve_ignt_c%0d", c), 32'(imem_gnt), 32'(exp_i));
      if (c == 0) begin
        check("starve_daddr", mem_addr, DAddr);
        check("starve_dwdata", mem_wdata, DWdata);
        check("starve_dstrb", 32'(mem_strb), 32'h3);
        check("starve_dwen", 32'(mem_wen), 32'd1);
      end
      tick();
    end
    imem_req = 1'b0;
    dmem_req = 1'b0;
    mem_gnt  = 1'b0;
    tick();

    // Lock on fetch while data arrives.
    imem_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) dmem_req = 1'b1;
      if (c == 3) mem_gnt = 1'b1;
      if (c == 4) imem_req = 1'b0;
      #2;
      check($sformatf("lock_addr_c%0d", c), mem_addr, (c == 4) ? DAddr : IAddr);
      check($sformatf("lock_ignt_c%0d", c), 32'(imem_gnt), 32'(c == 3));
      check($sformatf("lock_dgnt_c%0d", c), 32'(dmem_gnt), 32'(c == 4));
      tick();
    end
    dmem_req = 1'b0;
    mem_gnt  = 1'b0;
    tick();

    // Alternating grants with per-owner error routing.
    dmem_req = 1'b1;
    mem_gnt  = 1'b1;
    #2;
    check("alt_n_dgnt", 32'(dmem_gnt), 32'd1);
    tick();
    dmem_req  = 1'b0;
    imem_req  = 1'b1;
    mem_error = 1'b1;
    #2;
    check("alt_n1_ignt", 32'(imem_gnt), 32'd1);
    check("alt_n1_derr", 32'(dmem_error), 32'd1);
    check("alt_n1_ierr", 32'(imem_error), 32'd0);
    tick();
    imem_req = 1'b0;
    #2;
    check("alt_n2_ierr", 32'(imem_error), 32'd1);
    check("alt_n2_derr", 32'(dmem_error), 32'd0);
    tick();
    #2;
    check("alt_n3_ierr", 32'(imem_error), 32'd0);
    check("alt_n3_derr", 32'(dmem_error), 32'd0);
    tick();
    mem_error = 1'b0;
    mem_gnt   = 1'b0;

    // Reset mid-lock on data.
    imem_req = 1'b1;
    dmem_req = 1'b1;
    #2;
    check("rml_sel_daddr", mem_addr, DAddr);
    check("rml_dgnt0", 32'(dmem_gnt), 32'd0);
    tick();
    g_resetn  = 1'b0;
    mem_gnt   = 1'b1;
    mem_error = 1'b1;
    #2;
    check("rml_mem_req", 32'(mem_req), 32'd0);
    check("rml_ignt", 32'(imem_gnt), 32'd0);
    check("rml_dgnt", 32'(dmem_gnt), 32'd0);
    check("rml_ierr", 32'(imem_error), 32'd0);
    check("rml_derr", 32'(dmem_error), 32'd0);
    tick();
    g_resetn = 1'b1;
    dmem_req = 1'b0;
    #2;
    check("rml_post_ignt", 32'(imem_gnt), 32'd1);
    check("rml_post_dgnt", 32'(dmem_gnt), 32'd0);
    check("rml_post_addr", mem_addr, IAddr);
    check("rml_post_ierr", 32'(imem_error), 32'd0);
    check("rml_post_derr", 32'(dmem_error), 32'd0);
    tick();
    imem_req = 1'b0;
    mem_gnt  = 1'b0;
    #2;
    check("rml_rsp_ierr", 32'(imem_error), 32'd1);
    check("rml_rsp_derr", 32'(dmem_error), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
